// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port CPU register file.
package reg_file_pkg;

  localparam int REG_WIDTH  = 16;
  localparam int REG_ADDR_W = 3;

  typedef logic [REG_WIDTH-1:0]  reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic int reg_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int REG_DEPTH = reg_depth(REG_ADDR_W);

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write port bundle of the register file; ports are flattened, port p at [p*W +: W].
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);

  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*WIDTH-1:0]  rd_data;
  logic [NRD-1:0]        rd_valid;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*WIDTH-1:0]  wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One registered read port: array mux plus write-first bypass, 1-cycle latency, no stall.
// REG_FILE_ZERO_REG_EN forces address 0 to read as zero.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NWR    = 2,
  parameter int DEPTH  = reg_depth(ADDR_W)
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WIDTH-1:0]      mem [DEPTH],
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]      data,
  output logic                  valid
);

  logic [WIDTH-1:0] data_nxt;

  // Ascending scan so the highest-index matching write port wins.
  always_comb begin
    data_nxt = mem[addr];
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
        data_nxt = wr_data[w*WIDTH +: WIDTH];
      end
    end
`ifdef REG_FILE_ZERO_REG_EN
    if (addr == '0) begin
      data_nxt = '0;
    end
`endif
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        data <= data_nxt;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage array and write logic, NRD registered read ports.
// REG_FILE_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input logic          clk0,
  input logic          rst0_n,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = reg_depth(ADDR_W);

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] rd_dat_a [NRD];
  logic [NRD-1:0]   rd_vld_a;

  // Later ports overwrite earlier ones at the same address.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w]) begin
`ifdef REG_FILE_ZERO_REG_EN
          if (bus.wr_addr[w*ADDR_W +: ADDR_W] != '0)
`endif
            mem[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    reg_file_rd_port #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W),
      .NWR    (NWR),
      .DEPTH  (DEPTH)
    ) u_rd_port (
      .clk0    (clk0),
      .rst0_n  (rst0_n),
      .en      (bus.rd_en[p]),
      .addr    (bus.rd_addr[p*ADDR_W +: ADDR_W]),
      .mem     (mem),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (rd_dat_a[p]),
      .valid   (rd_vld_a[p])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      bus.rd_data[p*WIDTH +: WIDTH] = rd_dat_a[p];
    end
  end

  assign bus.rd_valid = rd_vld_a;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed cases plus random traffic vs an array model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int DEPTH  = 8;
`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic clk0 = 1'b0;
  logic rst0_n;

  reg_file_mp_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) bus ();

  reg_file_mp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .bus    (bus)
  );

  always #5 clk0 = ~clk0;

  int checks = 0;
  int errors = 0;

  reg_word_t model    [DEPTH];
  reg_word_t exp_data [NRD];
  logic      exp_vld  [NRD];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NRD; p++) begin
      check_val($sformatf("rd_data[%0d]", p), 32'(bus.rd_data[p*WIDTH +: WIDTH]), 32'(exp_data[p]));
      check_val($sformatf("rd_valid[%0d]", p), 32'(bus.rd_valid[p]), 32'(exp_vld[p]));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int p = 0; p < NRD; p++) begin
      exp_data[p] = '0;
      exp_vld[p]  = 1'b0;
    end
  endtask

  task automatic set_rd(input int p, input bit en, input int a);
    bus.rd_en[p] = en;
    bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic set_wr(input int w, input bit en, input int a, input logic [WIDTH-1:0] d);
    bus.wr_en[w] = en;
    bus.wr_addr[w*ADDR_W +: ADDR_W] = ADDR_W'(a);
    bus.wr_data[w*WIDTH +: WIDTH] = d;
  endtask

  task automatic idle_inputs();
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  // One clock: model applies all writes of the edge first, then serves reads from the result.
  task automatic step();
    int a;
    @(posedge clk0);
    if (!rst0_n) begin
      model_clear();
    end else begin
      for (int w = 0; w < NWR; w++) begin
        a = int'(bus.wr_addr[w*ADDR_W +: ADDR_W]);
        if (bus.wr_en[w] && !(ZERO_EN && a == 0)) model[a] = bus.wr_data[w*WIDTH +: WIDTH];
      end
      for (int p = 0; p < NRD; p++) begin
        exp_vld[p] = bus.rd_en[p];
        if (bus.rd_en[p]) exp_data[p] = model[int'(bus.rd_addr[p*ADDR_W +: ADDR_W])];
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst0_n = 1'b0;
    idle_inputs();
    model_clear();
    #2;
    check_outputs();
    step();
    rst0_n = 1'b1;

    // Every address after reset reads zero on both ports.
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, 1'b1, a);
      set_rd(1, 1'b1, DEPTH - 1 - a);
      step();
    end
    idle_inputs();
    step();

    set_wr(0, 1'b1, 0, 16'hABCD);
    set_wr(1, 1'b1, 1, 16'h1234);
    step();
    idle_inputs();
    set_rd(0, 1'b1, 1);
    set_rd(1, 1'b1, 0);
    step();
    check_val("cross_rd0", 32'(bus.rd_data[15:0]), 32'h1234);
    check_val("cross_rd1", 32'(bus.rd_data[31:16]), ZERO_EN ? 32'h0000 : 32'hABCD);

    // rd_en low: data holds, valid drops.
    idle_inputs();
    step();
    check_val("hold_rd0", 32'(bus.rd_data[15:0]), 32'h1234);
    check_val("hold_vld0", 32'(bus.rd_valid[0]), 32'h0);

    set_wr(0, 1'b1, 5, 16'hBEEF);
    set_rd(0, 1'b1, 5);
    step();
    check_val("bypass_rd0", 32'(bus.rd_data[15:0]), 32'hBEEF);

    idle_inputs();
    set_wr(0, 1'b1, 3, 16'h1111);
    set_wr(1, 1'b1, 3, 16'h2222);
    set_rd(1, 1'b1, 3);
    step();
    check_val("conflict_bypass", 32'(bus.rd_data[31:16]), 32'h2222);
    idle_inputs();
    set_rd(0, 1'b1, 3);
    step();
    check_val("conflict_read", 32'(bus.rd_data[15:0]), 32'h2222);

    // Port 1 to address 0 must not block port 0 writing elsewhere.
    idle_inputs();
    set_wr(0, 1'b1, 6, 16'h6666);
    set_wr(1, 1'b1, 0, 16'hFFFF);
    set_rd(0, 1'b1, 0);
    step();
    check_val("zero_bypass", 32'(bus.rd_data[15:0]), ZERO_EN ? 32'h0000 : 32'hFFFF);
    idle_inputs();
    set_rd(0, 1'b1, 0);
    set_rd(1, 1'b1, 6);
    step();
    check_val("zero_read", 32'(bus.rd_data[15:0]), ZERO_EN ? 32'h0000 : 32'hFFFF);
    check_val("zero_other", 32'(bus.rd_data[31:16]), 32'h6666);

    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
      for (int w = 0; w < NWR; w++)
        set_wr(w, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), WIDTH'($urandom));
      if ($urandom_range(0, 3) == 0) bus.wr_addr[ADDR_W +: ADDR_W] = bus.wr_addr[0 +: ADDR_W];
      if ($urandom_range(0, 3) == 0) bus.rd_addr[0 +: ADDR_W] = bus.wr_addr[0 +: ADDR_W];
      step();
    end

    // Asynchronous reset mid-cycle with reads in flight and writes pending.
    for (int p = 0; p < NRD; p++) set_rd(p, 1'b1, 3);
    step();
    for (int w = 0; w < NWR; w++) set_wr(w, 1'b1, w + 2, 16'h5A5A);
    #2;
    rst0_n = 1'b0;
    model_clear();
    #1;
    check_outputs();
    step();
    rst0_n = 1'b1;
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, 1'b1, a);
      set_rd(1, 1'b1, a);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file; the next generation of the 8x16, two-port CPU register file.
- Replaces the shared bidirectional data buses with separate read and write ports.
- Adds registered reads with valid flags, write-to-read bypass, and defined write-conflict priority.
- Sits between decode (addresses, enables) and the ALU/writeback stages of the CPU datapath.

Parameters:
- WIDTH, 16, data width of each register in bits.
- ADDR_W, 3, address width; depth is 2**ADDR_W registers.
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).

Ports:
- clk0  in  1  sole clock, rising edge.
- rst0_n  in  1  reset, asynchronous assert, active-low.
- rd_en  in  NRD  per-port read request.
- rd_addr  in  NRD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NRD*WIDTH  registered read data, port p at bits [p*WIDTH +: WIDTH].
- rd_valid  out  NRD  high for one cycle after an accepted read.
- wr_en  in  NWR  per-port write strobe.
- wr_addr  in  NWR*ADDR_W  write addresses.
- wr_data  in  NWR*WIDTH  write data.

Behaviour:
- Reset (rst0_n low, asynchronous): all registers, every rd_data and every rd_valid clear to 0. Deassertion takes effect at the next clk0 rising edge.
- Write: on each clk0 rising edge, every port w with wr_en[w]=1 writes wr_data[w] into reg[wr_addr[w]].
- Write conflict: if both ports write the same address, port NWR-1 (higher index) wins. Writes to different addresses both complete.
- Read latency is exactly 1 cycle. With rd_en[p]=1 at edge N:
  - rd_data[p] shows the register value at edge N (after N's writes are applied);
  - rd_valid[p]=1 during cycle N..N+1.
- Bypass (write-first): a read addressing a register written at the same edge returns the new data. If both write ports hit that address, it returns the winning port's data.
- rd_en[p]=0: rd_data[p] holds its previous value and rd_valid[p]=0 on the following cycle.
- Read ports are independent. All ports may read the same address in the same cycle.
- No internal FSM beyond the storage array and output registers. Every output is a flop; there are no combinational input-to-output paths.
- Reset mid-operation: in-flight reads are dropped (rd_valid goes 0 immediately). Writes presented in the reset cycle are lost.
- Out-of-range addresses cannot occur, because depth is a power of 2.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to 0 and writes to address 0 are discarded;
  - reads of address 0 return 0, including under bypass;
  - a conflicting write to address 0 does not mask a lower-priority write elsewhere.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package reg_file_pkg:
  - default constants: REG_WIDTH=16, REG_ADDR_W=3;
  - typedefs reg_word_t and reg_addr_t;
  - localparam for depth computation.
- One sub-module, reg_file_rd_port, instantiated NRD times via generate. It contains:
  - the read mux over the array;
  - bypass compare against all write ports with priority;
  - zero-register masking when enabled;
  - the rd_data/rd_valid output flops.
- The top level holds the storage array and the write logic.

Test Plan:
- Reset, then read all 8 addresses on both ports -> every rd_data=0000, rd_valid=1 one cycle after each rd_en.
- Write $0=ABCD (port 0) and $1=1234 (port 1) at edge N; at edge N+1 read port 0 addr 1 and port 1 addr 0 -> at N+2 rd_data[0]=1234, rd_data[1]=ABCD.
- Same-edge bypass: write $5=BEEF while reading $5 on port 0 -> next cycle rd_data[0]=BEEF.
- Write conflict: port 0 writes $3=1111 and port 1 writes $3=2222 at the same edge; read $3 -> 2222. With concurrent bypass read, also 2222.
- rd_en low after reading 1234 -> rd_data stays 1234, rd_valid=0. Assert rst0_n low mid-cycle -> outputs clear to 0 without waiting for a clock edge.
- With REG_FILE_ZERO_REG_EN: write $0=FFFF then read $0 -> 0000. Without it -> FFFF.
